inst_enc: RTL

Instruction encoder and program loader; the inverse of the core's instruction decoder. Accepts decoded fields (instruction class, rd/rs1/rs2, funct3/funct7, 32-bit immediate) over a valid/ready handshake and packs them into RV32I/M machine words. Words are buffered in a small FIFO and written sequentially into instruction memory. Used by the self-test/boot path to build programs in IMEM.

---
 rtl/inst_enc_if.sv | 34 +++
 rtl/inst_enc.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/inst_enc_if.sv
// Request and IMEM write bus for the instruction encoder.
// The encoder takes the slave side; the producer/IMEM side takes the master side.
interface inst_enc_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              i_clear;
    logic              i_valid;
    logic              o_ready;
    logic [3:0]        i_class;
    logic [2:0]        i_funct3;
    logic [6:0]        i_funct7;
    logic [4:0]        i_rd;
    logic [4:0]        i_rs1;
    logic [4:0]        i_rs2;
    logic [31:0]       i_imm;
    logic              o_mem_wen;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic              i_mem_ready;
    logic [15:0]       o_count;
    logic              o_err;

    modport slave (
        input  i_clear, i_valid, i_class, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm,
        input  i_mem_ready,
        output o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_err
    );

    modport master (
        output i_clear, i_valid, i_class, i_funct3, i_funct7, i_rd, i_rs1, i_rs2, i_imm,
        output i_mem_ready,
        input  o_ready, o_mem_wen, o_mem_addr, o_mem_wdata, o_count, o_err
    );
endinterface

// File: rtl/inst_enc.sv
// Packs decoded RV32I/M fields into machine words and streams them through a
// small FIFO into sequential IMEM addresses starting at BASE_ADDR.
module inst_enc #(
    parameter int unsigned       ADDR_W    = 10,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic       i_clk,
    input logic       i_rst_n,
    inst_enc_if.slave enc_bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(DEPTH);

    localparam logic [3:0] ClsLui    = 4'd0;
    localparam logic [3:0] ClsJal    = 4'd1;
    localparam logic [3:0] ClsJalr   = 4'd2;
    localparam logic [3:0] ClsBranch = 4'd3;
    localparam logic [3:0] ClsLoad   = 4'd4;
    localparam logic [3:0] ClsStore  = 4'd5;
    localparam logic [3:0] ClsOpImm  = 4'd6;
    localparam logic [3:0] ClsOp     = 4'd7;
    localparam logic [3:0] ClsEcall  = 4'd8;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpOpImm  = 7'b0010011;
    localparam logic [6:0] OpOp     = 7'b0110011;

    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] enc_word;
    logic        enc_illegal;

    assign imm = enc_bus.i_imm;
    assign f3  = enc_bus.i_funct3;
    assign f7  = enc_bus.i_funct7;
    assign rd  = enc_bus.i_rd;
    assign rs1 = enc_bus.i_rs1;
    assign rs2 = enc_bus.i_rs2;

    always_comb begin
        enc_word    = 32'h0;
        enc_illegal = 1'b0;
        case (enc_bus.i_class)
            ClsLui: enc_word = {imm[31:12], rd, OpLui};
            ClsJal: begin
                enc_word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpJal};
                enc_illegal = imm[0];
            end
            ClsJalr: enc_word = {imm[11:0], rs1, 3'b000, rd, OpJalr};
            ClsBranch: begin
                enc_word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OpBranch};
                enc_illegal = imm[0] || (f3 == 3'b010) || (f3 == 3'b011);
            end
            ClsLoad:  enc_word = {imm[11:0], rs1, f3, rd, OpLoad};
            ClsStore: enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], OpStore};
            ClsOpImm: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    // Shift-immediates carry funct7 above a 5-bit shamt; only SRAI may set bit 30.
                    enc_word    = {f7, imm[4:0], rs1, f3, rd, OpOpImm};
                    enc_illegal = !((f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'b101));
                end else begin
                    enc_word = {imm[11:0], rs1, f3, rd, OpOpImm};
                end
            end
            ClsOp: begin
                enc_word    = {f7, rs2, rs1, f3, rd, OpOp};
                enc_illegal = !((f7 == 7'h00) || (f7 == 7'h20) || (f7 == 7'h01));
            end
            ClsEcall: enc_word = 32'h0000_0073;
            default:  enc_illegal = 1'b1;
        endcase
    end

    logic [31:0]       fifo_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic              err_q, err_d;
    logic              full, empty, accept, push, pop;

    assign full   = (cnt_q == FullCnt);
    assign empty  = (cnt_q == '0);
    assign accept = enc_bus.i_valid && enc_bus.o_ready;
    assign push   = accept && !enc_illegal;
    assign pop    = !empty && enc_bus.i_mem_ready;

    assign enc_bus.o_ready     = !full && !enc_bus.i_clear;
    assign enc_bus.o_mem_wen   = !empty;
    assign enc_bus.o_mem_wdata = empty ? 32'h0 : fifo_q[rd_ptr_q];
    assign enc_bus.o_mem_addr  = addr_q;
    assign enc_bus.o_count     = count_q;
    assign enc_bus.o_err       = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        count_d  = count_q;
        err_d    = err_q;
        if (enc_bus.i_clear) begin
            // Flush wins over any write completing this cycle: it is neither advanced nor counted.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            addr_d   = BASE_ADDR;
            count_d  = '0;
            err_d    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                addr_d   = addr_q + ADDR_W'(4);
                count_d  = count_q + 16'd1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (PtrW + 1)'(1);
                2'b01:   cnt_d = cnt_q - (PtrW + 1)'(1);
                default: cnt_d = cnt_q;
            endcase
            if (accept && enc_illegal) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            addr_q   <= BASE_ADDR;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: the occupancy count gates every read.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule
